alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle operand/write-back controller that sits directly upstream and downstream of the 16-bit combinational ALU. It owns an 8×16 register file, accepts one encoded instruction at a time over a start/ready handshake, and fetches two source registers into registered operands. It drives the ALU's `inA`/`inB`/`inC`/`opc`, captures `outW`/`zer`/`neg`, writes the result back and updates status flags.

## Interface
- No parameters. Widths are fixed: data 16, register address 3, opcode 3.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: instruction valid; accepted only when `ready`=1.
- `instr` in 16: [15:13] opc, [12:10] dst, [9:7] srcA, [6:4] srcB, [3] cin, [2] cmp (see Configuration), [1:0] reserved/ignored.
- `ready` out 1: high in IDLE.
- `done` out 1: one-cycle pulse after write-back.
- `ld_en` in 1, `ld_addr` in 3, `ld_data` in 16: external register preload.
- `rd_addr` in 3, `rd_data` out 16: combinational debug read of the register file.
- `alu_a`, `alu_b` out 16: ALU operands, straight from operand registers.
- `alu_cin` out 1, `alu_opc` out 3: ALU carry-in and opcode, straight from the instruction register.
- `alu_w` in 16, `alu_zer` in 1, `alu_neg` in 1: ALU result and flags.
- `result` out 16: last captured ALU result.
- `flag_z`, `flag_n` out 1: registered status flags.

## Operation
- FSM states: IDLE, FETCH, EXEC, WB.
- IDLE: `ready`=1.
  - `start`=1 latches `instr` into the instruction register and moves to FETCH.
  - `start` outside IDLE is ignored; it is not queued.
- FETCH: `regs[srcA]`→opA and `regs[srcB]`→opB; next state EXEC. srcA may equal srcB.
- EXEC: the ALU evaluates combinationally on opA/opB/cin/opc.
  - Captures `alu_w`→`result`, `alu_zer`→z_tmp, `alu_neg`→n_tmp.
  - Next state WB.
- WB:
  - Writes `regs[dst]` ← `result`.
  - Updates `flag_z`/`flag_n` from z_tmp/n_tmp.
  - Sets `done` for the next cycle; next state IDLE.
- opc 111: the ALU returns 0. The sequencer still writes 0 to dst, giving flag_z=1, flag_n=0.
- dst may equal srcA/srcB; the sources are already latched, so no hazard.
- No register is hardwired to zero.
- Preload:
  - `ld_en` writes `regs[ld_addr]` ← `ld_data` only in IDLE; `ld_en` is ignored in other states.
  - `ld_en` and `start` in the same IDLE cycle: the load commits on that edge, and FETCH on the next edge sees the loaded value.
- Reset values: FSM=IDLE, `ready`=1, `done`=0, `result`=0, flags 0, all registers 0, operand and instruction registers 0.
  - Reset mid-instruction aborts it: no write-back and no `done`.

## Timing
- Accept edge E0 (start & ready): state FETCH after E0, `ready`=0.
- E1: operands latched; EXEC.
- E2: result captured; WB.
- E3: register and flags written; `done`=1 and `ready`=1 during the cycle after E3.
- Latency: start accepted to `done` high = 3 cycles.
- Throughput: one instruction per 4 cycles. A new `start` may be asserted in the same cycle as `done`.
- `rd_data` reflects the register write in the cycle after E3.

## Configuration
- `ALU_SEQ_CMP_EN` defined: `instr[2]`=1 marks compare-only.
  - WB updates `flag_z`/`flag_n` and `result` but suppresses the register write.
  - `done` is still pulsed.
- `ALU_SEQ_CMP_EN` undefined: `instr[2]` is ignored and every instruction writes dst.

## Test plan
- Reset: hold `rst_n`=0 mid-EXEC, release → `ready`=1, `done`=0, `result`=0, flags 0, `rd_data`=0 for all 8 addresses, no write occurred.
- Add with carry: preload R1=0x0005, R2=0x0003; instr opc=010 dst=3 srcA=1 srcB=2 cin=1 → `done` 3 cycles after accept, `result`=0x0009, R3=0x0009, z=0, n=0.
- Negate: R1=0x0005, opc=000 dst=4 srcA=1 → R4=0xFFFB, n=1, z=0.
- AND to zero: R1=0x00F0, R2=0x0F00, opc=100 dst=1 srcA=1 srcB=2 → R1=0x0000, z=1, n=0.
- Busy protection: `start` and `ld_en`(R5=0x1234) asserted during EXEC → only one `done`, R5 unchanged.
  - Same-cycle `ld_en` R6=0x7FFF with `start` opc=001 dst=6 srcA=6 → R6=0x8000, n=1.
- With `ALU_SEQ_CMP_EN`: R1=R2=0x0007, opc=010 cmp=1 dst=1 → z=0, n=0, R1 stays 0x0007, `result`=0x000E.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Operand fetch / write-back controller for the 16-bit combinational ALU, with an 8x16 register file.
// Optional compare-only instructions (instr[2]) are enabled by defining ALU_SEQ_CMP_EN.
module alu_op_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] instr,
    output logic        ready,
    output logic        done,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [15:0] ld_data,
    input  logic [2:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_cin,
    output logic [2:0]  alu_opc,
    input  logic [15:0] alu_w,
    input  logic        alu_zer,
    input  logic        alu_neg,
    output logic [15:0] result,
    output logic        flag_z,
    output logic        flag_n
);

    // state   | meaning
    // S_IDLE  | ready, accepts start / preload
    // S_FETCH | source registers -> operand registers
    // S_EXEC  | ALU result and flags captured
    // S_WB    | register and status flags written
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_WB} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_regs [8];
    logic [15:2] r_instr;
    logic [15:0] r_op_a;
    logic [15:0] r_op_b;
    logic [15:0] r_result;
    logic        r_z_tmp;
    logic        r_n_tmp;
    logic        r_flag_z;
    logic        r_flag_n;
    logic        r_done;

    logic        w_accept;
    logic        w_ld_we;
    logic        w_wb_we;
    logic [2:0]  w_dst;
    logic [2:0]  w_src_a;
    logic [2:0]  w_src_b;
    logic        w_unused;

    assign w_dst    = r_instr[12:10];
    assign w_src_a  = r_instr[9:7];
    assign w_src_b  = r_instr[6:4];
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_ld_we  = (r_state == S_IDLE) && ld_en;

`ifdef ALU_SEQ_CMP_EN
    assign w_wb_we  = (r_state == S_WB) && !r_instr[2];
    assign w_unused = ^instr[1:0];
`else
    assign w_wb_we  = (r_state == S_WB);
    assign w_unused = ^{instr[1:0], r_instr[2]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Preload and write-back never collide: preload is only honoured in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else if (w_ld_we) begin
            r_regs[ld_addr] <= ld_data;
        end else if (w_wb_we) begin
            r_regs[w_dst] <= r_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr  <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_z_tmp  <= 1'b0;
            r_n_tmp  <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_WB);
            if (w_accept) r_instr <= instr[15:2];
            if (r_state == S_FETCH) begin
                r_op_a <= r_regs[w_src_a];
                r_op_b <= r_regs[w_src_b];
            end
            if (r_state == S_EXEC) begin
                r_result <= alu_w;
                r_z_tmp  <= alu_zer;
                r_n_tmp  <= alu_neg;
            end
            if (r_state == S_WB) begin
                r_flag_z <= r_z_tmp;
                r_flag_n <= r_n_tmp;
            end
        end
    end

    assign ready   = (r_state == S_IDLE);
    assign done    = r_done;
    assign rd_data = r_regs[rd_addr];
    assign alu_a   = r_op_a;
    assign alu_b   = r_op_b;
    assign alu_cin = r_instr[3];
    assign alu_opc = r_instr[15:13];
    assign result  = r_result;
    assign flag_z  = r_flag_z;
    assign flag_n  = r_flag_n;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU stand-in plus a register-file reference model.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] instr = '0;
    logic        ready, done;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [2:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic [15:0] alu_a, alu_b, alu_w;
    logic        alu_cin, alu_zer, alu_neg;
    logic [2:0]  alu_opc;
    logic [15:0] result;
    logic        flag_z, flag_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_regs [8];
    logic [15:0] m_result;
    logic        m_z, m_n;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
        .ready(ready), .done(done),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opc(alu_opc),
        .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .result(result), .flag_z(flag_z), .flag_n(flag_n)
    );

    function automatic logic [15:0] alu_fn(input logic [2:0] opc, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
        case (opc)
            3'b000:  return 16'(0 - a);
            3'b001:  return 16'(a + 1);
            3'b010:  return 16'(a + b + {15'b0, cin});
            3'b011:  return 16'(a - b);
            3'b100:  return a & b;
            3'b101:  return a | b;
            3'b110:  return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_w   = alu_fn(alu_opc, alu_a, alu_b, alu_cin);
    assign alu_zer = (alu_w == 16'h0000);
    assign alu_neg = alu_w[15];

    function automatic logic [15:0] mk(input logic [2:0] opc, input logic [2:0] dst,
                                       input logic [2:0] sa, input logic [2:0] sb,
                                       input logic cin, input logic cmp);
        return {opc, dst, sa, sb, cin, cmp, 2'b00};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_result = '0;
        m_z = 1'b0;
        m_n = 1'b0;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            check(tag, rd_data, m_regs[i]);
        end
        @(negedge clk);
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
        m_regs[a] = d;
    endtask

    // Called just after a negedge with the DUT idle; returns just after the negedge where done is high.
    task automatic run_instr(input logic [15:0] ins, input bit same_ld, input logic [2:0] la,
                             input logic [15:0] ld, input bit poke);
        int          cyc;
        logic [15:0] ea, eb, ew;
        bit          wr;
        check("ready_idle", 16'(ready), 16'h1);
        start = 1'b1;
        instr = ins;
        if (same_ld) begin
            ld_en = 1'b1; ld_addr = la; ld_data = ld;
            m_regs[la] = ld;
        end
        ea = m_regs[ins[9:7]];
        eb = m_regs[ins[6:4]];
        ew = alu_fn(ins[15:13], ea, eb, ins[3]);
        wr = 1'b1;
`ifdef ALU_SEQ_CMP_EN
        if (ins[2]) wr = 1'b0;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        ld_en = 1'b0;
        @(negedge clk);
        check("ready_busy", 16'(ready), 16'h0);
        check("done_pulse", 16'(done), 16'h0);
        cyc = 0;
        while (!done && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("alu_a", alu_a, ea);
                check("alu_b", alu_b, eb);
                check("alu_ctl", {12'b0, alu_cin, alu_opc}, {12'b0, ins[3], ins[15:13]});
                if (poke) begin
                    start = 1'b1;
                    instr = 16'($urandom);
                    ld_en = 1'b1; ld_addr = 3'd5; ld_data = 16'h1234;
                end
            end
            if (cyc == 2) begin
                start = 1'b0;
                ld_en = 1'b0;
            end
        end
        check("latency", 16'(cyc), 16'd3);
        m_result = ew;
        m_z = (ew == 16'h0000);
        m_n = ew[15];
        if (wr) m_regs[ins[12:10]] = ew;
        check("result", result, m_result);
        check("flag_z", 16'(flag_z), 16'(m_z));
        check("flag_n", 16'(flag_n), 16'(m_n));
        check("ready_done", 16'(ready), 16'h1);
        rd_addr = ins[12:10];
        #1;
        check("rd_dst", rd_data, m_regs[ins[12:10]]);
    endtask

    initial begin
        logic [15:0] ins;
        model_reset();
        #23;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready", 16'(ready), 16'h1);
        check("rst_done", 16'(done), 16'h0);
        check("rst_result", result, 16'h0);
        check("rst_flags", {14'b0, flag_z, flag_n}, 16'h0);
        check_all_regs("rst_regs");

        // reset in the middle of EXEC must abort the write-back
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        start = 1'b1;
        instr = mk(3'b010, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("abort_ready", 16'(ready), 16'h1);
        check("abort_result", result, 16'h0);
        check("abort_flags", {14'b0, flag_z, flag_n}, 16'h0);
        for (int i = 0; i < 4; i++) begin
            check("abort_no_done", 16'(done), 16'h0);
            @(negedge clk);
        end
        check_all_regs("abort_regs");

        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        run_instr(mk(3'b010, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0), 0, 3'd0, 16'h0, 0);
        check("add_value", result, 16'h0009);
        @(negedge clk);
        run_instr(mk(3'b000, 3'd4, 3'd1, 3'd0, 1'b0, 1'b0), 0, 3'd0, 16'h0, 0);
        check("neg_value", result, 16'hFFFB);
        check("neg_flag_n", 16'(flag_n), 16'h1);
        @(negedge clk);
        preload(3'd1, 16'h00F0);
        preload(3'd2, 16'h0F00);
        run_instr(mk(3'b100, 3'd1, 3'd1, 3'd2, 1'b0, 1'b0), 0, 3'd0, 16'h0, 0);
        check("and_flag_z", 16'(flag_z), 16'h1);
        @(negedge clk);

        // start and preload during EXEC are dropped
        run_instr(mk(3'b101, 3'd7, 3'd2, 3'd4, 1'b0, 1'b0), 0, 3'd0, 16'h0, 1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("busy_one_done", 16'(done), 16'h0);
            @(negedge clk);
        end
        check_all_regs("busy_regs");

        run_instr(mk(3'b001, 3'd6, 3'd6, 3'd0, 1'b0, 1'b0), 1, 3'd6, 16'h7FFF, 0);
        check("same_cycle_ld", result, 16'h8000);
        @(negedge clk);
        run_instr(mk(3'b111, 3'd2, 3'd4, 3'd4, 1'b1, 1'b0), 0, 3'd0, 16'h0, 0);
        check("opc111_z", 16'(flag_z), 16'h1);
        @(negedge clk);

`ifdef ALU_SEQ_CMP_EN
        preload(3'd1, 16'h0007);
        preload(3'd2, 16'h0007);
        run_instr(mk(3'b010, 3'd1, 3'd1, 3'd2, 1'b0, 1'b1), 0, 3'd0, 16'h0, 0);
        check("cmp_result", result, 16'h000E);
        check("cmp_keep_r1", rd_data, 16'h0007);
        @(negedge clk);
`endif

        // random traffic, issued back-to-back in the done cycle
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) preload(3'($urandom), 16'($urandom));
            ins = 16'($urandom);
            if ($urandom_range(0, 4) == 0) ins[15:13] = 3'b111;
            run_instr(ins, 1'($urandom_range(0, 3) == 0), 3'($urandom), 16'($urandom),
                      1'($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);
        check_all_regs("final_regs");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 ns");
        $fatal(1);
    end

endmodule
